// File: rtl/parking_occupancy_counter_pkg.sv
// Shared types, constants and BCD helpers for the parking occupancy counter.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EN_A,
    EN_AB,
    EN_B,
    EX_B,
    EX_BA,
    EX_A
  } state_e;

  typedef logic [3:0] digit_t;
  typedef digit_t [3:0] bcd4_t;

  localparam digit_t      BCD_MAX_DIGIT = 4'd9;
  localparam int unsigned SYNC_STAGES   = 2;

  function automatic bcd4_t to_bcd4(input int unsigned v);
    bcd4_t r;
    r[3] = digit_t'((v / 1000) % 10);
    r[2] = digit_t'((v / 100) % 10);
    r[1] = digit_t'((v / 10) % 10);
    r[0] = digit_t'(v % 10);
    return r;
  endfunction

  // Ripple increment: 9 wraps to 0 and carries into the next digit.
  function automatic bcd4_t bcd_inc(input bcd4_t v);
    bcd4_t r;
    logic  carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i] >= BCD_MAX_DIGIT) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = v[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple decrement: 0 wraps to 9 and borrows from the next digit.
  function automatic bcd4_t bcd_dec(input bcd4_t v);
    bcd4_t r;
    logic  borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[i] == 4'd0) begin
          r[i] = BCD_MAX_DIGIT;
        end else begin
          r[i]   = v[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/parking_occupancy_counter_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce counter.
module sensor_debounce
  import parking_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic deb_o
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   deb_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign deb_o  = deb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  // Toggle only after DB_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else if (synced != deb_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        cnt_q <= '0;
        deb_q <= synced;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/parking_occupancy_counter.sv
// Gate sensor decoder and saturating 4-digit BCD occupancy counter that
// feeds the seven-segment display controller.
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY  = 100,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sensor_a,
  input  logic        sensor_b,
  output logic [15:0] number,
  output logic        full,
  output logic        empty,
  output logic        car_in,
  output logic        car_out
);

  localparam bcd4_t CAP_BCD = to_bcd4(CAPACITY);

  logic       deb_a;
  logic       deb_b;
  logic [1:0] ab;

  state_e state_q;
  logic   entry_q;
  logic   exit_q;

  bcd4_t count_q, count_d;
  logic  full_q, full_d;
  logic  empty_q, empty_d;
  logic  car_in_q, car_in_d;
  logic  car_out_q, car_out_d;

  sensor_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .raw_i (sensor_a),
    .deb_o (deb_a)
  );

  sensor_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .raw_i (sensor_b),
    .deb_o (deb_b)
  );

  assign ab = {deb_a, deb_b};

  // A/B ordering decoder; entry_q / exit_q flag a completed passage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ab == 2'b10)      state_q <= EN_A;
          else if (ab == 2'b01) state_q <= EX_B;
        end
        EN_A: begin
          if (ab == 2'b11)      state_q <= EN_AB;
          else if (ab != 2'b10) state_q <= IDLE;
        end
        EN_AB: begin
          if (ab == 2'b01)      state_q <= EN_B;
          else if (ab == 2'b10) state_q <= EN_A;
          else if (ab == 2'b00) state_q <= IDLE;
        end
        EN_B: begin
          if (ab == 2'b00) begin
            state_q <= IDLE;
            entry_q <= 1'b1;
          end else if (ab == 2'b11) begin
            state_q <= EN_AB;
          end else if (ab == 2'b10) begin
            state_q <= IDLE;
          end
        end
        EX_B: begin
          if (ab == 2'b11)      state_q <= EX_BA;
          else if (ab != 2'b01) state_q <= IDLE;
        end
        EX_BA: begin
          if (ab == 2'b10)      state_q <= EX_A;
          else if (ab == 2'b01) state_q <= EX_B;
          else if (ab == 2'b00) state_q <= IDLE;
        end
        EX_A: begin
          if (ab == 2'b00) begin
            state_q <= IDLE;
            exit_q  <= 1'b1;
          end else if (ab == 2'b11) begin
            state_q <= EX_BA;
          end else if (ab == 2'b01) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Saturating count; flags are derived from the next count so they track number.
  always_comb begin
    count_d   = count_q;
    car_in_d  = 1'b0;
    car_out_d = 1'b0;
    if (entry_q && (count_q != CAP_BCD)) begin
      count_d  = bcd_inc(count_q);
      car_in_d = 1'b1;
    end else if (exit_q && (count_q != '0)) begin
      count_d   = bcd_dec(count_q);
      car_out_d = 1'b1;
    end
    full_d  = (count_d == CAP_BCD);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      car_in_q  <= 1'b0;
      car_out_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      car_in_q  <= car_in_d;
      car_out_q <= car_out_d;
    end
  end

  assign number  = count_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign car_in  = car_in_q;
  assign car_out = car_out_q;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Directed bench for parking_occupancy_counter with a short debounce window.
module tb_parking_occupancy_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sensor_a;
  logic        sensor_b;
  logic [15:0] number;
  logic        full;
  logic        empty;
  logic        car_in;
  logic        car_out;

  int errors = 0;
  int checks = 0;
  int in_cnt = 0;
  int out_cnt = 0;

  parking_occupancy_counter #(.CAPACITY(100), .DB_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .sensor_a (sensor_a),
    .sensor_b (sensor_b),
    .number   (number),
    .full     (full),
    .empty    (empty),
    .car_in   (car_in),
    .car_out  (car_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (car_in === 1'b1)  in_cnt++;
    if (car_out === 1'b1) out_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  task automatic hold(input logic a, input logic b, input int n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) @(posedge clk);
  endtask

  task automatic enter();
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 10);
  endtask

  task automatic leave();
    hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
  endtask

  task automatic do_reset();
    sensor_a = 0;
    sensor_b = 0;
    reset    = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    in_cnt  = 0;
    out_cnt = 0;
    hold(0, 0, 50);
    @(negedge clk);
    checks++; if (number !== 16'h0000) begin errors++; $display("FAIL reset_number: got %h expected 0000", number); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (in_cnt !== 0) begin errors++; $display("FAIL reset_car_in: got %0d pulses expected 0", in_cnt); end
    checks++; if (out_cnt !== 0) begin errors++; $display("FAIL reset_car_out: got %0d pulses expected 0", out_cnt); end
  endtask

  task automatic test_entry_exit();
    int i0, o0;
    i0 = in_cnt;
    enter();
    @(negedge clk);
    checks++; if (in_cnt - i0 !== 1) begin errors++; $display("FAIL entry_pulse: got %0d pulses expected 1", in_cnt - i0); end
    checks++; if (number !== 16'h0001) begin errors++; $display("FAIL entry_number: got %h expected 0001", number); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL entry_empty: got %b expected 0", empty); end
    o0 = out_cnt;
    leave();
    @(negedge clk);
    checks++; if (out_cnt - o0 !== 1) begin errors++; $display("FAIL exit_pulse: got %0d pulses expected 1", out_cnt - o0); end
    checks++; if (number !== 16'h0000) begin errors++; $display("FAIL exit_number: got %h expected 0000", number); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL exit_empty: got %b expected 1", empty); end
  endtask

  task automatic test_carry_and_full();
    int i0;
    for (int k = 0; k < 9; k++) enter();
    @(negedge clk);
    checks++; if (number !== 16'h0009) begin errors++; $display("FAIL carry_9: got %h expected 0009", number); end
    enter();
    @(negedge clk);
    checks++; if (number !== 16'h0010) begin errors++; $display("FAIL carry_10: got %h expected 0010", number); end
    for (int k = 0; k < 89; k++) enter();
    @(negedge clk);
    checks++; if (number !== 16'h0099) begin errors++; $display("FAIL carry_99: got %h expected 0099", number); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL not_full_99: got %b expected 0", full); end
    enter();
    @(negedge clk);
    checks++; if (number !== 16'h0100) begin errors++; $display("FAIL full_number: got %h expected 0100", number); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", full); end
    i0 = in_cnt;
    enter();
    @(negedge clk);
    checks++; if (number !== 16'h0100) begin errors++; $display("FAIL saturate_number: got %h expected 0100", number); end
    checks++; if (in_cnt - i0 !== 0) begin errors++; $display("FAIL saturate_pulse: got %0d pulses expected 0", in_cnt - i0); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL saturate_full: got %b expected 1", full); end
  endtask

  task automatic test_aborts();
    int i0;
    do_reset();
    i0 = in_cnt;
    hold(1, 0, 10); hold(0, 0, 10);
    @(negedge clk);
    checks++; if (number !== 16'h0000) begin errors++; $display("FAIL balk: got %h expected 0000", number); end
    hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
    @(negedge clk);
    checks++; if (number !== 16'h0000) begin errors++; $display("FAIL back_out: got %h expected 0000", number); end
    checks++; if (in_cnt - i0 !== 0) begin errors++; $display("FAIL abort_pulses: got %0d pulses expected 0", in_cnt - i0); end
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 10);
    @(negedge clk);
    checks++; if (in_cnt - i0 !== 1) begin errors++; $display("FAIL backtrack_pulse: got %0d pulses expected 1", in_cnt - i0); end
    checks++; if (number !== 16'h0001) begin errors++; $display("FAIL backtrack_number: got %h expected 0001", number); end
  endtask

  task automatic test_chatter_and_empty();
    int i0, o0;
    i0 = in_cnt;
    o0 = out_cnt;
    for (int k = 0; k < 10; k++) begin
      hold(1, 0, 3);
      hold(0, 0, 1);
    end
    hold(0, 0, 10);
    @(negedge clk);
    checks++; if (number !== 16'h0001) begin errors++; $display("FAIL chatter_number: got %h expected 0001", number); end
    checks++; if ((in_cnt - i0) + (out_cnt - o0) !== 0) begin errors++; $display("FAIL chatter_pulses: got %0d pulses expected 0", (in_cnt - i0) + (out_cnt - o0)); end
    leave();
    @(negedge clk);
    checks++; if (number !== 16'h0000) begin errors++; $display("FAIL drain_number: got %h expected 0000", number); end
    o0 = out_cnt;
    leave();
    @(negedge clk);
    checks++; if (out_cnt - o0 !== 0) begin errors++; $display("FAIL empty_exit_pulse: got %0d pulses expected 0", out_cnt - o0); end
    checks++; if (number !== 16'h0000) begin errors++; $display("FAIL empty_exit_number: got %h expected 0000", number); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL empty_exit_flag: got %b expected 1", empty); end
  endtask

  task automatic test_async_reset();
    int i0, o0;
    for (int k = 0; k < 42; k++) enter();
    @(negedge clk);
    checks++; if (number !== 16'h0042) begin errors++; $display("FAIL pre_reset_number: got %h expected 0042", number); end
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
    @(negedge clk);
    #1 reset = 1;
    #1;
    checks++; if (number !== 16'h0000) begin errors++; $display("FAIL async_reset_number: got %h expected 0000", number); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL async_reset_empty: got %b expected 1", empty); end
    repeat (2) @(posedge clk);
    #1 reset = 0;
    i0 = in_cnt;
    o0 = out_cnt;
    hold(0, 1, 10); hold(0, 0, 10);
    @(negedge clk);
    checks++; if ((in_cnt - i0) + (out_cnt - o0) !== 0) begin errors++; $display("FAIL post_reset_pulses: got %0d pulses expected 0", (in_cnt - i0) + (out_cnt - o0)); end
    checks++; if (number !== 16'h0000) begin errors++; $display("FAIL post_reset_number: got %h expected 0000", number); end
  endtask

  initial begin
    reset    = 1;
    sensor_a = 0;
    sensor_b = 0;
    test_reset();
    test_entry_exit();
    test_carry_and_full();
    test_aborts();
    test_chatter_and_empty();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parking_occupancy_counter.md
Name: parking_occupancy_counter

Overview:
Upstream feeder of the 4-digit seven-segment display controller in the parking-lot counter design. Takes two raw beam sensors at the gate (A = outer, B = inner), synchronises and debounces them, and decodes the A/B ordering with an FSM to recognise a complete car entry or exit. Maintains a saturating 4-digit BCD occupancy count presented as the 16-bit `number` bus that the display controller consumes directly.

Parameters:
- CAPACITY, 100, maximum occupancy; legal range 1..9999, decimal.
- DB_CYCLES, 1000000, consecutive stable cycles required before a debounced sensor changes (10 ms at 100 MHz); minimum 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sensor_a  input  1  raw outer beam, 1 = blocked, asynchronous to clk
- sensor_b  input  1  raw inner beam, 1 = blocked, asynchronous to clk
- number  output  16  BCD occupancy; [15:12] thousands … [3:0] units
- full  output  1  high when count == CAPACITY
- empty  output  1  high when count == 0
- car_in  output  1  one-cycle pulse on a counted entry
- car_out  output  1  one-cycle pulse on a counted exit

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk. All flops clear asynchronously.
  - Reset values: number = 16'h0000, empty = 1, full = 0, car_in = 0, car_out = 0.
  - Reset also clears the synchronisers, the debounced values (0), the debounce counters and the FSM state (IDLE).
  - Reset asserted mid-sequence abandons the sequence; no count change.
- Input conditioning: each sensor passes through a 2-flop synchroniser, then a debouncer.
  - The debounced output toggles only after the synced input has differed from it for DB_CYCLES consecutive cycles.
  - Any agreeing cycle clears that channel's counter.
  - Raw-to-debounced latency = 2 + DB_CYCLES cycles.
- FSM input is ab = {deb_a, deb_b}. States and transitions:
  - IDLE: 10 -> EN_A; 01 -> EX_B; 11 -> IDLE (ambiguous, ignored); 00 stays.
  - EN_A: 11 -> EN_AB; 00 -> IDLE (balk); 01 -> IDLE; 10 stays.
  - EN_AB: 01 -> EN_B; 10 -> EN_A (backing out); 00 -> IDLE; 11 stays.
  - EN_B: 00 -> IDLE and raise entry event; 11 -> EN_AB; 10 -> IDLE; 01 stays.
  - EX_B / EX_BA / EX_A mirror the entry states with A and B swapped; EX_A -> 00 raises the exit event.
- Count update: registered, takes effect the cycle after the event-raising transition; car_in / car_out assert in that same cycle as number changes.
  - Entry while count == CAPACITY: count holds, no car_in.
  - Exit while count == 0: count holds, no car_out.
- BCD arithmetic: per-digit ripple.
  - Increment: digit 9 -> 0 with carry into the next digit.
  - Decrement: digit 0 -> 9 with borrow.
  - Every digit stays in 0..9 at all times; a binary count is never kept.
- full and empty are registered, consistent with number in the same cycle.
- Events are mutually exclusive by construction: at most one FSM transition per cycle.

Decomposition:
- Shared package parking_pkg:
  - FSM state enum (IDLE, EN_A, EN_AB, EN_B, EX_B, EX_BA, EX_A).
  - 4-bit BCD digit typedef and 16-bit bcd4 typedef.
  - Constants BCD_MAX_DIGIT = 9 and SYNC_STAGES = 2.
  - A function converting the decimal CAPACITY to bcd4 for the compare.
- One sub-module, sensor_debounce (synchroniser + debounce counter, parameter DB_CYCLES), instantiated once per sensor.
- FSM and BCD counter remain in the top module.

Test Plan:
All scenarios use DB_CYCLES = 4.
- Reset, then hold both sensors at 0 for 50 cycles -> number = 0x0000, empty = 1, full = 0, no pulses.
- Sensor sequence 10, 11, 01, 00 (each held 10 cycles) -> one car_in pulse, number = 0x0001, empty = 0. Then 01, 11, 10, 00 -> one car_out pulse, number = 0x0000.
- 9 entries then 1 more -> number walks 0x0009 -> 0x0010 (BCD carry). 100 total with CAPACITY = 100 -> number = 0x0100, full = 1. A 101st entry -> number stays 0x0100, no car_in.
- Aborted and backtracking paths:
  - 10, 00 (balk) -> no count.
  - 10, 11, 10, 00 -> no count.
  - 10, 11, 01, 11, 01, 00 -> exactly one car_in.
- Chatter on sensor_a: 3-cycle pulses separated by 1-cycle gaps -> deb_a never changes, number unchanged. With count = 0x0000, run an exit sequence -> no car_out, number stays 0x0000.
- Assert reset while in EN_B with count = 0x0042 -> number = 0x0000 immediately (asynchronous). After release, 01, 00 -> no event.
